// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with burst lock.
// One registered output stream shared by NREQ valid/ready lanes.
module stream_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int SRCW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_rdy,
  output logic                  out_vld,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SRCW-1:0]       out_src,
  input  logic                  out_rdy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state;
  logic             en;
  logic [SRCW-1:0]  ptr;
  logic [SRCW-1:0]  owner;
  logic [NREQ-1:0]  mask;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  gnt;
  logic             slot_free;
  logic             xfer;
  logic [SRCW-1:0]  g_idx;
  logic [WIDTH-1:0] g_data;
  logic             g_last;

  assign slot_free = ~out_vld | out_rdy;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++)
      mask[i] = SRCW'(i) > ptr;
  end

  // Lanes above ptr first; wrap to the whole set when none of them ask.
  assign cand = |(req_vld & mask) ? (req_vld & mask) : req_vld;

  always_comb begin
    gnt = '0;
    unique case (state)
      IDLE: gnt = cand & (~cand + NREQ'(1));
      LOCK: gnt = (NREQ'(1) << owner) & req_vld;
      default: gnt = '0;
    endcase
  end

  assign req_rdy = {NREQ{en & slot_free}} & gnt;
  assign xfer    = |req_rdy;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) g_idx = SRCW'(i);
  end

  assign g_data = req_data[g_idx*WIDTH +: WIDTH];
  assign g_last = req_last[g_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en    <= 1'b0;
      state <= IDLE;
      ptr   <= SRCW'(NREQ-1);
      owner <= '0;
    end else begin
      en <= 1'b1;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (g_last) begin
              ptr <= g_idx;
            end else begin
              state <= LOCK;
              owner <= g_idx;
            end
          end
          LOCK: begin
            if (g_last) begin
              state <= IDLE;
              ptr   <= owner;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_src  <= '0;
    end else if (xfer) begin
      out_vld  <= 1'b1;
      out_data <= g_data;
      out_last <= g_last;
      out_src  <= g_idx;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter with burst lock that shares a single registered output stream among NREQ valid/ready requesters. A burst is a sequence of beats ending in a beat with last=1; once a lane wins, it holds the output until its last beat is accepted. Rotating priority starts from the lane after the previous burst owner. The block sits in front of any shared single-port consumer, such as a write port, bus master or rotate/mux datapath stage.

## Interface
- NREQ, 4: number of requesters; legal range 2..16.
- WIDTH, 16: payload width per beat.
- SRCW, `CLOG2(NREQ): width of the owner index.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  NREQ  per-lane beat valid.
- req_data  in  NREQ*WIDTH  flattened payloads; lane i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  per-lane end-of-burst marker, qualified by req_vld.
- req_rdy  out  NREQ  per-lane accept; at most one bit is high in any cycle.
- out_vld  out  1  output beat valid (registered).
- out_data  out  WIDTH  output payload (registered).
- out_last  out  1  output end-of-burst (registered).
- out_src  out  SRCW  index of the lane that supplied the output beat (registered).
- out_rdy  in  1  downstream accept.

## Operation
- Transfer rules:
  - An input transfer on lane i occurs when req_vld[i] & req_rdy[i] are both high.
  - An output transfer occurs when out_vld & out_rdy are both high.
- slot_free = ~out_vld | out_rdy. The output register can take a new beat in the same cycle the current one drains.
- en: a flop reset to 0 that sets to 1 on the first clock after rst_n deasserts. It gates all req_rdy bits.
- req_rdy[i] = en & slot_free & gnt[i], where gnt is the one-hot grant below.
- State IDLE (reset state):
  - Build mask = lanes with index > ptr, using a thermal mask of ptr.
  - If req_vld & mask ≠ 0, grant the lowest-index set bit of req_vld & mask. Otherwise grant the lowest-index set bit of req_vld.
  - If req_vld = 0, gnt = 0.
  - On an input transfer from lane g with req_last[g]=1: stay in IDLE, ptr <= g.
  - On an input transfer from lane g with req_last[g]=0: go to LOCK, owner <= g.
  - If no input transfer occurs (slot full or en=0), gnt is recomputed each cycle and no lock is taken.
- State LOCK:
  - gnt = onehot(owner) & req_vld; all other lanes see req_rdy=0.
  - If the owner drops req_vld mid-burst, the lock is held indefinitely with no timeout.
  - On an owner transfer with req_last=1: go to IDLE, ptr <= owner.
- Output register:
  - On an input transfer: out_vld <= 1, out_data <= lane payload, out_last <= req_last[g], out_src <= g.
  - Otherwise, if out_rdy: out_vld <= 0 and the data fields hold their values.
- Priority pointer:
  - ptr resets to NREQ-1, so lane 0 has top priority after reset.
  - ptr updates only on burst completion, never on an IDLE cycle without a transfer.
- Combinational path: req_rdy depends on req_vld, which is the arbitration path. Requesters must not derive req_vld from req_rdy.
- Reset mid-burst: state returns to IDLE, ptr to NREQ-1, and the output register clears. The partially sent burst is lost; upstream and downstream are reset together.

## Timing
- Reset values:
  - out_vld=0, out_data=0, out_last=0, out_src=0.
  - req_rdy=0 while rst_n is low and during the first clock after release (en=0).
- Latency: an input transfer in cycle N produces out_vld=1 with that beat in cycle N+1.
- Throughput: 1 beat per cycle when out_rdy is held at 1.
- No bubble cycles:
  - None between beats of a burst.
  - None on an IDLE->LOCK or LOCK->IDLE switch; a new owner may transfer in the cycle after the previous last beat.
- Backpressure: out_rdy=0 with out_vld=1 forces all req_rdy to 0 in the same cycle. out_data, out_last and out_src stay stable until out_rdy is seen.
- Single-beat bursts (last=1 on the first beat) never enter LOCK but still advance ptr.

## Test plan
- Reset then fairness: hold req_vld=4'b1111 with all single-beat bursts and out_rdy=1. Required out_src sequence: 0,1,2,3,0,1; first out_vld in cycle 3 after reset release.
- Lock hold: lane 1 sends a 3-beat burst (last on beat 3) while lanes 0 and 2 request continuously. Required: out_src = 1,1,1, then 2 (ptr was 1), then 0.
- Owner gap: lane 2 is locked and drops req_vld for 4 cycles mid-burst while lane 0 requests. Required: req_rdy[0] stays 0 throughout, and lane 2 completes its burst before lane 0 is granted.
- Backpressure: 2-beat burst from lane 3 with out_rdy=0 for 5 cycles after the first beat. Required: out_data holds beat 1, req_rdy=0, and beat 2 transfers the cycle out_rdy rises.
- Wrap-around: ptr=3 and req_vld=4'b1001. Required grant: lane 0; lane 3 is granted next.
- Reset mid-burst: assert rst_n=0 during a lane-2 LOCK. Required: out_vld drops immediately, and after release lane 0 wins over lane 2 with both requesting.
